// File: rtl/mem_bus_arbiter.sv
// Arbitrates the shared memory bus between instruction fetch and the MEM stage.
// One transaction at a time, alternating grants on ties; a silent slave is aborted with an error.
module mem_bus_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_err,
  output logic              if_stall,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              mem_ack,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_err,
  output logic              mem_stall,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_ack,
  input  logic [DATA_W-1:0] bus_rdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_BUSY_IF,
    S_BUSY_MEM,
    S_DONE_IF,
    S_DONE_MEM
  } state_t;

  // The counter aborts on the cycle it reaches this value with no ack.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t            r_state;
  logic              r_last_mem;
  logic [7:0]        r_cnt;
  logic              r_bus_req;
  logic              r_bus_we;
  logic [ADDR_W-1:0] r_bus_addr;
  logic [DATA_W-1:0] r_bus_wdata;
  logic              r_if_ack;
  logic              r_if_err;
  logic [DATA_W-1:0] r_if_rdata;
  logic              r_mem_ack;
  logic              r_mem_err;
  logic [DATA_W-1:0] r_mem_rdata;

  logic              w_grant_mem;
  logic              w_busy_end;
  logic [DATA_W-1:0] w_cpl_rdata;

  // MEM wins when alone, or on a tie when IF was granted last.
  assign w_grant_mem = mem_req && (!if_req || !r_last_mem);
  assign w_busy_end  = bus_ack || (r_cnt == CNT_LAST);
  // Timeouts and writes complete with zero data.
  assign w_cpl_rdata = (bus_ack && !r_bus_we) ? bus_rdata : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_last_mem  <= 1'b0;
      r_cnt       <= '0;
      r_bus_req   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_wdata <= '0;
      r_if_ack    <= 1'b0;
      r_if_err    <= 1'b0;
      r_if_rdata  <= '0;
      r_mem_ack   <= 1'b0;
      r_mem_err   <= 1'b0;
      r_mem_rdata <= '0;
    end else begin
      r_if_ack  <= 1'b0;
      r_mem_ack <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_grant_mem) begin
            r_state     <= S_BUSY_MEM;
            r_last_mem  <= 1'b1;
            r_bus_req   <= 1'b1;
            r_bus_we    <= mem_we;
            r_bus_addr  <= mem_addr;
            r_bus_wdata <= mem_wdata;
            r_cnt       <= '0;
          end else if (if_req) begin
            r_state     <= S_BUSY_IF;
            r_last_mem  <= 1'b0;
            r_bus_req   <= 1'b1;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= if_addr;
            r_bus_wdata <= '0;
            r_cnt       <= '0;
          end
        end
        S_BUSY_IF, S_BUSY_MEM: begin
          if (w_busy_end) begin
            r_bus_req <= 1'b0;
            if (r_state == S_BUSY_MEM) begin
              r_mem_rdata <= w_cpl_rdata;
              r_mem_err   <= !bus_ack;
              r_mem_ack   <= 1'b1;
              r_state     <= S_DONE_MEM;
            end else begin
              r_if_rdata <= w_cpl_rdata;
              r_if_err   <= !bus_ack;
              r_if_ack   <= 1'b1;
              r_state    <= S_DONE_IF;
            end
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_DONE_IF, S_DONE_MEM: r_state <= S_IDLE;
        default:               r_state <= S_IDLE;
      endcase
    end
  end

  assign bus_req   = r_bus_req;
  assign bus_we    = r_bus_we;
  assign bus_addr  = r_bus_addr;
  assign bus_wdata = r_bus_wdata;
  assign if_ack    = r_if_ack;
  assign if_err    = r_if_err;
  assign if_rdata  = r_if_rdata;
  assign mem_ack   = r_mem_ack;
  assign mem_err   = r_mem_err;
  assign mem_rdata = r_mem_rdata;
  assign if_stall  = if_req && !r_if_ack;
  assign mem_stall = mem_req && !r_mem_ack;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: expected bus transactions and acks are queued
// by each scenario and consumed by the per-cycle monitor in tick().
module tb_mem_bus_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  logic          clk;
  logic          rst_n;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_ack;
  logic [DW-1:0] if_rdata;
  logic          if_err;
  logic          if_stall;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;
  logic          mem_err;
  logic          mem_stall;
  logic          bus_req;
  logic          bus_we;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wdata;
  logic          bus_ack;
  logic [DW-1:0] bus_rdata;

  mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .if_err(if_err), .if_stall(if_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .mem_err(mem_err), .mem_stall(mem_stall),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic          we;
    logic [DW-1:0] wdata;
  } bus_exp_t;

  typedef struct {
    logic          is_mem;
    logic [DW-1:0] rdata;
    logic          err;
  } ack_exp_t;

  bus_exp_t bus_q[$];
  ack_exp_t ack_q[$];
  int       ack_cyc_q[$];
  bus_exp_t cur_bus;
  logic     cur_valid;
  logic     prev_bus_req;
  int       checks, errors, cyc;
  int       bus_txn_cnt, bus_hi_cnt, if_ack_cnt, mem_ack_cnt;
  int       last_if_ack_cyc, last_mem_ack_cyc;
  logic     last_if_ack_stall;
  logic     slave_en, inj_ack;
  int       slave_wait, wcnt;
  logic [DW-1:0] slave_key;
  logic     if_auto_drop, mem_auto_drop;

  task automatic push_bus(input logic [AW-1:0] a, input logic we, input logic [DW-1:0] wd);
    bus_exp_t b;
    b.addr = a; b.we = we; b.wdata = wd;
    bus_q.push_back(b);
  endtask

  task automatic push_ack(input logic is_mem, input logic [DW-1:0] rd, input logic err);
    ack_exp_t e;
    e.is_mem = is_mem; e.rdata = rd; e.err = err;
    ack_q.push_back(e);
  endtask

  // One cycle: observe at the falling edge, then drive the slave for the next rising edge.
  task automatic tick();
    ack_exp_t e;
    @(negedge clk);
    cyc++;
    checks++;
    if (if_stall !== (if_req & ~if_ack)) begin
      errors++;
      $display("FAIL if_stall cyc %0d: got %b want %b", cyc, if_stall, if_req & ~if_ack);
    end
    checks++;
    if (mem_stall !== (mem_req & ~mem_ack)) begin
      errors++;
      $display("FAIL mem_stall cyc %0d: got %b want %b", cyc, mem_stall, mem_req & ~mem_ack);
    end
    if (bus_req === 1'b1) begin
      bus_hi_cnt++;
      if (prev_bus_req !== 1'b1) begin
        bus_txn_cnt++;
        checks++;
        if (bus_q.size() == 0) begin
          errors++;
          cur_valid = 1'b0;
          $display("FAIL bus_txn cyc %0d: got unexpected transaction addr %h, want none", cyc, bus_addr);
        end else begin
          cur_bus = bus_q.pop_front();
          cur_valid = 1'b1;
        end
      end
      if (cur_valid) begin
        checks++;
        if (bus_addr !== cur_bus.addr || bus_we !== cur_bus.we || bus_wdata !== cur_bus.wdata) begin
          errors++;
          $display("FAIL bus_fields cyc %0d: got addr %h we %b wdata %h want addr %h we %b wdata %h",
                   cyc, bus_addr, bus_we, bus_wdata, cur_bus.addr, cur_bus.we, cur_bus.wdata);
        end
      end
    end
    prev_bus_req = bus_req;
    if (if_ack === 1'b1) begin
      if_ack_cnt++;
      last_if_ack_cyc = cyc;
      last_if_ack_stall = if_stall;
      ack_cyc_q.push_back(cyc);
      checks++;
      if (ack_q.size() == 0) begin
        errors++;
        $display("FAIL if_ack cyc %0d: got unexpected ack, want none", cyc);
      end else begin
        e = ack_q.pop_front();
        if (e.is_mem !== 1'b0 || if_rdata !== e.rdata || if_err !== e.err) begin
          errors++;
          $display("FAIL if_ack cyc %0d: got IF rdata %h err %b want %s rdata %h err %b",
                   cyc, if_rdata, if_err, e.is_mem ? "MEM" : "IF", e.rdata, e.err);
        end
      end
      if (if_auto_drop) if_req = 1'b0;
    end
    if (mem_ack === 1'b1) begin
      mem_ack_cnt++;
      last_mem_ack_cyc = cyc;
      ack_cyc_q.push_back(cyc);
      checks++;
      if (ack_q.size() == 0) begin
        errors++;
        $display("FAIL mem_ack cyc %0d: got unexpected ack, want none", cyc);
      end else begin
        e = ack_q.pop_front();
        if (e.is_mem !== 1'b1 || mem_rdata !== e.rdata || mem_err !== e.err) begin
          errors++;
          $display("FAIL mem_ack cyc %0d: got MEM rdata %h err %b want %s rdata %h err %b",
                   cyc, mem_rdata, mem_err, e.is_mem ? "MEM" : "IF", e.rdata, e.err);
        end
      end
      if (mem_auto_drop) mem_req = 1'b0;
    end
    if (inj_ack) begin
      bus_ack = 1'b1;
      bus_rdata = 32'hBAD0_BAD0;
      inj_ack = 1'b0;
    end else if (slave_en && bus_req === 1'b1) begin
      if (wcnt == slave_wait) begin
        bus_ack = 1'b1;
        bus_rdata = bus_addr ^ slave_key;
        wcnt = 0;
      end else begin
        bus_ack = 1'b0;
        wcnt++;
      end
    end else begin
      bus_ack = 1'b0;
      wcnt = 0;
    end
  endtask

  task automatic wait_acks(input int if_target, input int mem_target, input int budget, output bit ok);
    int k;
    k = 0;
    while ((if_ack_cnt < if_target || mem_ack_cnt < mem_target) && k < budget) begin
      tick();
      k++;
    end
    ok = (if_ack_cnt >= if_target) && (mem_ack_cnt >= mem_target);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    checks++;
    if ({bus_req, bus_we, bus_addr, bus_wdata} !== '0) begin
      errors++;
      $display("FAIL reset_bus: got req %b we %b addr %h wdata %h want all 0", bus_req, bus_we, bus_addr, bus_wdata);
    end
    checks++;
    if ({if_ack, if_err, if_rdata, if_stall} !== '0) begin
      errors++;
      $display("FAIL reset_if: got ack %b err %b rdata %h stall %b want all 0", if_ack, if_err, if_rdata, if_stall);
    end
    checks++;
    if ({mem_ack, mem_err, mem_rdata, mem_stall} !== '0) begin
      errors++;
      $display("FAIL reset_mem: got ack %b err %b rdata %h stall %b want all 0", mem_ack, mem_err, mem_rdata, mem_stall);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_if_read();
    int req_cyc, hi0;
    bit ok;
    slave_en = 1'b1; slave_wait = 2;
    if_addr = 32'h1000_0040;
    slave_key = 32'h1000_0040 ^ 32'hDEAD_BEEF;
    push_bus(32'h1000_0040, 1'b0, '0);
    push_ack(1'b0, 32'hDEAD_BEEF, 1'b0);
    if_auto_drop = 1'b1;
    if_req = 1'b1;
    req_cyc = cyc;
    hi0 = bus_hi_cnt;
    tick();
    checks++;
    if (bus_req !== 1'b1) begin
      errors++;
      $display("FAIL if_read_grant_latency: got bus_req %b want 1", bus_req);
    end
    if_addr = 32'hFFFF_0000;
    wait_acks(if_ack_cnt + 1, mem_ack_cnt, 20, ok);
    checks++;
    if (!ok || last_if_ack_cyc != req_cyc + 4) begin
      errors++;
      $display("FAIL if_read_ack_cycle: got ok %0d at %0d want at %0d", ok, last_if_ack_cyc - req_cyc, 4);
    end
    checks++;
    if (last_if_ack_stall !== 1'b0 || bus_hi_cnt - hi0 != 3) begin
      errors++;
      $display("FAIL if_read_stall_bus: got stall %b bus_cycles %0d want 0 and 3", last_if_ack_stall, bus_hi_cnt - hi0);
    end
    repeat (3) tick();
    checks++;
    if (if_rdata !== 32'hDEAD_BEEF || if_ack !== 1'b0) begin
      errors++;
      $display("FAIL if_rdata_hold: got rdata %h ack %b want deadbeef and 0", if_rdata, if_ack);
    end
  endtask

  task automatic test_mem_write();
    int req_cyc;
    bit ok;
    slave_en = 1'b1; slave_wait = 0; slave_key = 32'hFFFF_FFFF;
    mem_we = 1'b1; mem_addr = 32'h0000_0100; mem_wdata = 32'h1234_5678;
    push_bus(32'h0000_0100, 1'b1, 32'h1234_5678);
    push_ack(1'b1, 32'h0, 1'b0);
    mem_auto_drop = 1'b1;
    mem_req = 1'b1;
    req_cyc = cyc;
    wait_acks(if_ack_cnt, mem_ack_cnt + 1, 20, ok);
    checks++;
    if (!ok || last_mem_ack_cyc != req_cyc + 2) begin
      errors++;
      $display("FAIL mem_write_ack_cycle: got ok %0d at +%0d want at +2", ok, last_mem_ack_cyc - req_cyc);
    end
    mem_we = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_tie();
    bit ok;
    int i0, m0;
    slave_en = 1'b1; slave_wait = 0; slave_key = 32'hA5A5_5A5A;
    if_addr = 32'h0000_2000; mem_addr = 32'h0000_3000; mem_we = 1'b0; mem_wdata = 32'h1111_2222;
    if_auto_drop = 1'b0; mem_auto_drop = 1'b0;
    rst_n = 1'b0;
    if_req = 1'b1; mem_req = 1'b1;
    bus_q.delete(); ack_q.delete();
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      push_bus(32'h0000_3000, 1'b0, 32'h1111_2222);
      push_ack(1'b1, 32'h0000_3000 ^ 32'hA5A5_5A5A, 1'b0);
      push_bus(32'h0000_2000, 1'b0, '0);
      push_ack(1'b0, 32'h0000_2000 ^ 32'hA5A5_5A5A, 1'b0);
    end
    ack_cyc_q.delete();
    i0 = if_ack_cnt; m0 = mem_ack_cnt;
    wait_acks(i0 + 2, m0 + 2, 40, ok);
    if_req = 1'b0; mem_req = 1'b0;
    checks++;
    if (!ok || ack_cyc_q.size() != 4) begin
      errors++;
      $display("FAIL tie_ack_count: got ok %0d acks %0d want 4", ok, ack_cyc_q.size());
    end else begin
      for (int k = 1; k < 4; k++) begin
        checks++;
        if (ack_cyc_q[k] - ack_cyc_q[k-1] != 3) begin
          errors++;
          $display("FAIL tie_ack_gap %0d: got %0d cycles want 3", k, ack_cyc_q[k] - ack_cyc_q[k-1]);
        end
      end
    end
    repeat (3) tick();
    checks++;
    if (bus_q.size() != 0 || ack_q.size() != 0) begin
      errors++;
      $display("FAIL tie_leftover: got bus %0d ack %0d pending want 0", bus_q.size(), ack_q.size());
    end
  endtask

  task automatic test_timeout();
    int req_cyc, hi0, txn0, m0;
    bit ok;
    slave_en = 1'b0;
    mem_we = 1'b0; mem_addr = 32'h0000_0400; mem_wdata = 32'h0;
    push_bus(32'h0000_0400, 1'b0, 32'h0);
    push_ack(1'b1, 32'h0, 1'b1);
    mem_auto_drop = 1'b1;
    mem_req = 1'b1;
    req_cyc = cyc;
    hi0 = bus_hi_cnt;
    wait_acks(if_ack_cnt, mem_ack_cnt + 1, 20, ok);
    checks++;
    if (!ok || bus_hi_cnt - hi0 != TO) begin
      errors++;
      $display("FAIL timeout_bus_cycles: got ok %0d cycles %0d want %0d", ok, bus_hi_cnt - hi0, TO);
    end
    checks++;
    if (last_mem_ack_cyc != req_cyc + TO + 1) begin
      errors++;
      $display("FAIL timeout_ack_cycle: got +%0d want +%0d", last_mem_ack_cyc - req_cyc, TO + 1);
    end
    tick();
    inj_ack = 1'b1;
    txn0 = bus_txn_cnt; m0 = mem_ack_cnt;
    repeat (5) tick();
    checks++;
    if (mem_ack_cnt != m0 || bus_txn_cnt != txn0 || bus_req !== 1'b0) begin
      errors++;
      $display("FAIL late_ack_ignored: got acks %0d txns %0d bus_req %b want %0d %0d 0",
               mem_ack_cnt, bus_txn_cnt, bus_req, m0, txn0);
    end
    slave_en = 1'b1; slave_wait = 0; slave_key = 32'h0F0F_0F0F;
    if_addr = 32'h0000_0500;
    push_bus(32'h0000_0500, 1'b0, '0);
    push_ack(1'b0, 32'h0000_0500 ^ 32'h0F0F_0F0F, 1'b0);
    if_auto_drop = 1'b1;
    if_req = 1'b1;
    req_cyc = cyc;
    wait_acks(if_ack_cnt + 1, mem_ack_cnt, 20, ok);
    checks++;
    if (!ok || last_if_ack_cyc != req_cyc + 2) begin
      errors++;
      $display("FAIL after_timeout_read: got ok %0d at +%0d want +2", ok, last_if_ack_cyc - req_cyc);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    bit ok;
    int i0, m0, txn0;
    slave_en = 1'b1; slave_wait = 0; slave_key = 32'h0000_00FF;
    if_auto_drop = 1'b1; mem_auto_drop = 1'b1;
    // Leave MEM as the last grant, then reset while idle: the next tie must still go to MEM.
    mem_we = 1'b0; mem_addr = 32'h0000_0600; mem_wdata = 32'h0;
    push_bus(32'h0000_0600, 1'b0, 32'h0);
    push_ack(1'b1, 32'h0000_0600 ^ 32'h0000_00FF, 1'b0);
    mem_req = 1'b1;
    wait_acks(if_ack_cnt, mem_ack_cnt + 1, 20, ok);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    if_addr = 32'h0000_0700;
    push_bus(32'h0000_0600, 1'b0, 32'h0);
    push_ack(1'b1, 32'h0000_0600 ^ 32'h0000_00FF, 1'b0);
    push_bus(32'h0000_0700, 1'b0, '0);
    push_ack(1'b0, 32'h0000_0700 ^ 32'h0000_00FF, 1'b0);
    ack_cyc_q.delete();
    mem_req = 1'b1; if_req = 1'b1;
    wait_acks(if_ack_cnt + 1, mem_ack_cnt + 1, 30, ok);
    checks++;
    if (!ok || ack_q.size() != 0) begin
      errors++;
      $display("FAIL reset_idle_tie: got ok %0d pending %0d want 1 0", ok, ack_q.size());
    end
    tick();
    // Abandon an IF read while the bus is waiting.
    slave_en = 1'b0;
    if_addr = 32'h0000_0800;
    push_bus(32'h0000_0800, 1'b0, '0);
    if_req = 1'b1;
    tick();
    tick();
    checks++;
    if (bus_req !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_busy: got bus_req %b want 1", bus_req);
    end
    rst_n = 1'b0;
    if_req = 1'b0;
    i0 = if_ack_cnt; m0 = mem_ack_cnt;
    tick();
    rst_n = 1'b1;
    checks++;
    if ({bus_req, bus_we, bus_addr, bus_wdata, if_ack, if_err, if_rdata, if_stall,
         mem_ack, mem_err, mem_rdata, mem_stall} !== '0) begin
      errors++;
      $display("FAIL reset_mid_outputs: got bus_req %b addr %h if_ack %b if_rdata %h mem_ack %b mem_rdata %h want all 0",
               bus_req, bus_addr, if_ack, if_rdata, mem_ack, mem_rdata);
    end
    inj_ack = 1'b1;
    txn0 = bus_txn_cnt;
    repeat (4) tick();
    checks++;
    if (if_ack_cnt != i0 || mem_ack_cnt != m0 || bus_txn_cnt != txn0) begin
      errors++;
      $display("FAIL reset_mid_no_ack: got if %0d mem %0d txn %0d want %0d %0d %0d",
               if_ack_cnt, mem_ack_cnt, bus_txn_cnt, i0, m0, txn0);
    end
    slave_en = 1'b1;
    mem_addr = 32'h0000_0900; if_addr = 32'h0000_0A00;
    push_bus(32'h0000_0900, 1'b0, 32'h0);
    push_ack(1'b1, 32'h0000_0900 ^ 32'h0000_00FF, 1'b0);
    push_bus(32'h0000_0A00, 1'b0, '0);
    push_ack(1'b0, 32'h0000_0A00 ^ 32'h0000_00FF, 1'b0);
    mem_req = 1'b1; if_req = 1'b1;
    wait_acks(if_ack_cnt + 1, mem_ack_cnt + 1, 30, ok);
    checks++;
    if (!ok || last_mem_ack_cyc >= last_if_ack_cyc) begin
      errors++;
      $display("FAIL reset_mid_tie: got ok %0d mem_ack %0d if_ack %0d want MEM first", ok, last_mem_ack_cyc, last_if_ack_cyc);
    end
    tick();
  endtask

  task automatic test_hold_through_done();
    bit ok;
    int i0, txn0;
    slave_en = 1'b1; slave_wait = 0; slave_key = 32'h3333_0000;
    if_auto_drop = 1'b0;
    if_addr = 32'h0000_0B00;
    push_bus(32'h0000_0B00, 1'b0, '0);
    push_ack(1'b0, 32'h0000_0B00 ^ 32'h3333_0000, 1'b0);
    i0 = if_ack_cnt; txn0 = bus_txn_cnt;
    if_req = 1'b1;
    wait_acks(i0 + 1, mem_ack_cnt, 20, ok);
    @(posedge clk);
    #1 if_req = 1'b0;
    repeat (6) tick();
    checks++;
    if (!ok || if_ack_cnt != i0 + 1 || bus_txn_cnt != txn0 + 1) begin
      errors++;
      $display("FAIL hold_through_done: got ok %0d acks %0d txns %0d want 1 1",
               ok, if_ack_cnt - i0, bus_txn_cnt - txn0);
    end
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0;
    bus_txn_cnt = 0; bus_hi_cnt = 0; if_ack_cnt = 0; mem_ack_cnt = 0;
    last_if_ack_cyc = 0; last_mem_ack_cyc = 0; last_if_ack_stall = 1'b0;
    cur_valid = 1'b0; prev_bus_req = 1'b0;
    slave_en = 1'b0; inj_ack = 1'b0; slave_wait = 0; wcnt = 0; slave_key = '0;
    if_auto_drop = 1'b1; mem_auto_drop = 1'b1;
    rst_n = 1'b0;
    if_req = 1'b0; if_addr = '0;
    mem_req = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_wdata = '0;
    bus_ack = 1'b0; bus_rdata = '0;
    test_reset();
    test_if_read();
    test_mem_write();
    test_tie();
    test_timeout();
    test_reset_mid();
    test_hold_through_done();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single external memory bus between two requesters: instruction fetch (IF, read-only) and the MEM stage (read/write, fed by the EX/MEM register).
- Grants one transaction at a time and drives the bus handshake.
- Returns read data, completion and error to the granted requester.
- Produces per-requester stall signals used to hold the IF/ID and EX/MEM pipeline registers.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- TIMEOUT_CYCLES, 255, number of BUSY cycles without bus_ack before aborting with an error. Legal range 1..255.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- if_req  in  1  IF read request; held until if_ack
- if_addr  in  ADDR_W  IF address; stable while if_req
- if_ack  out  1  one-cycle IF completion pulse
- if_rdata  out  DATA_W  IF read data; valid with if_ack
- if_err  out  1  IF timeout flag; valid with if_ack
- if_stall  out  1  if_req && !if_ack
- mem_req  in  1  MEM request; held until mem_ack
- mem_we  in  1  1 = write, 0 = read
- mem_addr  in  ADDR_W  MEM address
- mem_wdata  in  DATA_W  MEM write data
- mem_ack  out  1  one-cycle MEM completion pulse
- mem_rdata  out  DATA_W  MEM read data; valid with mem_ack
- mem_err  out  1  MEM timeout flag; valid with mem_ack
- mem_stall  out  1  mem_req && !mem_ack
- bus_req  out  1  bus request; held until bus_ack or timeout
- bus_we  out  1  bus write enable
- bus_addr  out  ADDR_W  bus address
- bus_wdata  out  DATA_W  bus write data
- bus_ack  in  1  slave completion, single-cycle pulse
- bus_rdata  in  DATA_W  slave read data; valid with bus_ack

Behaviour:
- Reset (rst_n=0 at posedge):
  - state=IDLE, last_grant=IF, timeout counter=0.
  - bus_req/bus_we=0, bus_addr/bus_wdata=0.
  - if_ack/mem_ack/if_err/mem_err=0, if_rdata/mem_rdata=0.
  - Reset mid-transaction abandons it silently. No ack or err is issued for the abandoned transaction.
- States: IDLE, BUSY_IF, BUSY_MEM, DONE_IF, DONE_MEM.
- IDLE:
  - Only mem_req -> BUSY_MEM.
  - Only if_req -> BUSY_IF.
  - Both -> grant the requester not equal to last_grant; update last_grant. First tie after reset goes to MEM.
  - On entering BUSY: register bus_addr/bus_we/bus_wdata from the granted requester (IF forces we=0, wdata=0). Set bus_req=1 and counter=0.
- BUSY_x:
  - bus outputs stay constant.
  - bus_ack=1 at posedge -> capture bus_rdata into x_rdata (writes capture 0); x_err=0; bus_req=0; go to DONE_x.
  - No bus_ack: counter increments. When counter == TIMEOUT_CYCLES-1 with no ack -> x_rdata=0, x_err=1, bus_req=0, go to DONE_x.
- DONE_x:
  - x_ack=1 for exactly this cycle, then unconditionally IDLE.
  - Requests are not sampled in DONE, so a requester still holding req during its ack cycle is never double-granted.
- Latency:
  - Request seen in IDLE at edge n -> bus_req high from cycle n+1.
  - bus_ack sampled at edge m -> x_ack high in cycle m+1.
  - Minimum request-to-ack is 3 cycles with a zero-wait slave.
- Timing of rdata and err:
  - x_rdata and x_err hold their value until the next completion for the same requester.
  - x_err is meaningful only while x_ack=1.
- bus_ack outside BUSY (late ack after timeout, spurious ack) is ignored with no state change.
- The non-granted requester's stall stays high for the whole transaction. Stalls are purely combinational from req and ack.
- Requester inputs are not re-sampled after grant. Changes while granted have no effect on the bus.

Test Plan:
- Single IF read, slave acks 2 cycles after bus_req, rdata=0xDEADBEEF -> bus_addr=if_addr, bus_we=0; if_ack one cycle with if_rdata=0xDEADBEEF, if_err=0; if_stall low in the ack cycle.
- MEM write addr=0x100, wdata=0x12345678, zero-wait slave -> bus_we=1, bus_wdata=0x12345678; mem_ack at cycle 3 after mem_req; mem_rdata=0.
- if_req and mem_req both held continuously from reset, zero-wait slave -> grant order MEM, IF, MEM, IF; each ack separated by an IDLE cycle; the other requester's stall is high throughout.
- TIMEOUT_CYCLES=4, slave never acks -> bus_req high exactly 4 cycles; then mem_ack=1, mem_err=1, mem_rdata=0. A bus_ack injected 2 cycles later causes no ack and no state change.
- rst_n low for 1 cycle while in BUSY_IF with bus_req high -> all outputs at reset values next cycle; no if_ack. A bus_ack after reset is ignored. The next tie is granted to MEM.
- Requester holds req through its DONE cycle and drops it at the next edge -> exactly one ack and exactly one bus transaction.
